clock_set_ctrl: RTL and testbench

Time-setting controller for the digital clock. It sequences the BCD hh:mm:ss counter between run, hold and load through its 2-bit mode input, and builds the 24-bit load word from three push-buttons. It sits between the debounced button inputs and the time counter. It also drives field-select and blink outputs for the display.

---
 rtl/clock_pkg.sv | 52 +++++
 rtl/bcd_field_step.sv | 37 +++
 rtl/clock_set_ctrl.sv | 150 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared states, mode/field codes and BCD limits for the
//               digital clock time-setting path.
// Revision    : 1.0
// ============================================================================
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_EDIT_H = 3'd1,
        ST_EDIT_M = 3'd2,
        ST_EDIT_S = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;

    localparam logic [1:0] FLD_NONE = 2'b00;
    localparam logic [1:0] FLD_H    = 2'b01;
    localparam logic [1:0] FLD_M    = 2'b10;
    localparam logic [1:0] FLD_S    = 2'b11;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    function automatic logic [1:0] mode_of(input state_t st);
        case (st)
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: mode_of = MODE_HOLD;
            ST_COMMIT:                       mode_of = MODE_LOAD;
            default:                         mode_of = MODE_RUN;
        endcase
    endfunction

    function automatic logic [1:0] field_of(input state_t st);
        case (st)
            ST_EDIT_H: field_of = FLD_H;
            ST_EDIT_M: field_of = FLD_M;
            ST_EDIT_S: field_of = FLD_S;
            default:   field_of = FLD_NONE;
        endcase
    endfunction

    function automatic logic is_edit(input state_t st);
        is_edit = (st == ST_EDIT_H) || (st == ST_EDIT_M) || (st == ST_EDIT_S);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_field_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_field_step
// Description : Combinational +/-1 step of a two-digit BCD field, 00..MAX.
// Revision    : 1.0
// ============================================================================
module bcd_field_step #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic [7:0] i_val,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [7:0] o_val
);

    // inc and dec together cancel out
    always_comb begin
        o_val = i_val;
        if (i_inc && !i_dec) begin
            if (i_val == MAX)
                o_val = 8'h00;
            else if (i_val[3:0] == 4'd9)
                o_val = {i_val[7:4] + 4'd1, 4'd0};
            else
                o_val = {i_val[7:4], i_val[3:0] + 4'd1};
        end else if (i_dec && !i_inc) begin
            if (i_val == 8'h00)
                o_val = MAX;
            else if (i_val[3:0] == 4'd0)
                o_val = {i_val[7:4] - 4'd1, 4'd9};
            else
                o_val = {i_val[7:4], i_val[3:0] - 4'd1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_ctrl
// Description : Run/hold/load sequencer and button-driven shadow time editor.
// Revision    : 1.0
// ============================================================================
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic        clk_1hz,
    input  logic        rst,
    input  logic        btn_set,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] time_cur,
    output logic [1:0]  clk_mode,
    output logic [23:0] time_load,
    output logic [1:0]  edit_field,
    output logic        blink
);

    localparam logic [7:0] C_IDLE_LAST = 8'(TIMEOUT_S - 1);

    logic       r_prev_set, r_prev_inc, r_prev_dec;
    logic       w_set_e, w_inc_e, w_dec_e, w_any_e;
    logic       w_step_inc, w_step_dec;
    state_t     r_state, w_state_nxt;
    logic [7:0] r_hour, r_min, r_sec;
    logic [7:0] w_hour_nxt, w_min_nxt, w_sec_nxt;
    logic [7:0] w_hour_step, w_min_step, w_sec_step;
    logic [7:0] r_idle, w_idle_nxt;
    logic       w_blink_nxt;

    assign w_set_e    = btn_set & ~r_prev_set;
    assign w_inc_e    = btn_inc & ~r_prev_inc;
    assign w_dec_e    = btn_dec & ~r_prev_dec;
    assign w_any_e    = w_set_e | w_inc_e | w_dec_e;
    // a set edge swallows any coincident step
    assign w_step_inc = w_inc_e & ~w_set_e;
    assign w_step_dec = w_dec_e & ~w_set_e;

    bcd_field_step #(.MAX(HOUR_MAX)) u_step_hour (
        .i_val (r_hour),
        .i_inc (w_step_inc),
        .i_dec (w_step_dec),
        .o_val (w_hour_step)
    );

    bcd_field_step #(.MAX(MINSEC_MAX)) u_step_min (
        .i_val (r_min),
        .i_inc (w_step_inc),
        .i_dec (w_step_dec),
        .o_val (w_min_step)
    );

    bcd_field_step #(.MAX(MINSEC_MAX)) u_step_sec (
        .i_val (r_sec),
        .i_inc (w_step_inc),
        .i_dec (w_step_dec),
        .o_val (w_sec_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hour_nxt  = r_hour;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_idle_nxt  = r_idle;
        case (r_state)
            ST_RUN: begin
                w_idle_nxt = 8'd0;
                if (w_set_e) begin
                    w_state_nxt = ST_EDIT_H;
                    w_hour_nxt  = time_cur[23:16];
                    w_min_nxt   = time_cur[15:8];
                    w_sec_nxt   = time_cur[7:0];
                end
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                if (w_set_e) begin
                    case (r_state)
                        ST_EDIT_H: w_state_nxt = ST_EDIT_M;
                        ST_EDIT_M: w_state_nxt = ST_EDIT_S;
                        default:   w_state_nxt = ST_COMMIT;
                    endcase
                end else begin
                    case (r_state)
                        ST_EDIT_H: w_hour_nxt = w_hour_step;
                        ST_EDIT_M: w_min_nxt  = w_min_step;
                        default:   w_sec_nxt  = w_sec_step;
                    endcase
                end
                if (w_any_e) begin
                    w_idle_nxt = 8'd0;
                end else if (r_idle == C_IDLE_LAST) begin
                    // abandon the edit; the counter resumes from its held value
                    w_state_nxt = ST_RUN;
                    w_idle_nxt  = 8'd0;
                end else begin
                    w_idle_nxt = r_idle + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_idle_nxt  = 8'd0;
            end
        endcase

        if (!is_edit(w_state_nxt))
            w_blink_nxt = 1'b0;
        else if (r_state == ST_RUN)
            w_blink_nxt = 1'b1;
        else
            w_blink_nxt = ~blink;
    end

    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            r_prev_set <= 1'b0;
            r_prev_inc <= 1'b0;
            r_prev_dec <= 1'b0;
            r_state    <= ST_RUN;
            r_hour     <= 8'h00;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
            r_idle     <= 8'd0;
            clk_mode   <= MODE_RUN;
            edit_field <= FLD_NONE;
            blink      <= 1'b0;
        end else begin
            r_prev_set <= btn_set;
            r_prev_inc <= btn_inc;
            r_prev_dec <= btn_dec;
            r_state    <= w_state_nxt;
            r_hour     <= w_hour_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_idle     <= w_idle_nxt;
            clk_mode   <= mode_of(w_state_nxt);
            edit_field <= field_of(w_state_nxt);
            blink      <= w_blink_nxt;
        end
    end

    assign time_load = {r_hour, r_min, r_sec};

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_set_ctrl
// Description : Directed scoreboard bench for clock_set_ctrl (TIMEOUT_S=4).
// Revision    : 1.0
// ============================================================================
module tb_clock_set_ctrl;

    logic        clk_1hz = 1'b0;
    logic        rst;
    logic        btn_set, btn_inc, btn_dec;
    logic [23:0] time_cur;
    logic [1:0]  clk_mode;
    logic [23:0] time_load;
    logic [1:0]  edit_field;
    logic        blink;

    typedef struct packed {
        logic [1:0]  mode;
        logic [23:0] load;
        logic [1:0]  field;
        logic        blink;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    clock_set_ctrl #(.TIMEOUT_S(4)) dut (
        .clk_1hz    (clk_1hz),
        .rst        (rst),
        .btn_set    (btn_set),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .time_cur   (time_cur),
        .clk_mode   (clk_mode),
        .time_load  (time_load),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 clk_1hz = ~clk_1hz;

    function automatic obs_t observed();
        return {clk_mode, time_load, edit_field, blink};
    endfunction

    task automatic check(input string nm, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got mode=%b load=%h field=%b blink=%b, want mode=%b load=%h field=%b blink=%b",
                     nm, act.mode, act.load, act.field, act.blink,
                     exp.mode, exp.load, exp.field, exp.blink);
        end
    endtask

    // Monitor: registered outputs are settled by the falling edge
    always @(negedge clk_1hz) begin
        obs_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, observed(), e);
        end
    end

    task automatic cyc(input string nm, input logic s, input logic i, input logic d,
                       input logic [1:0] m, input logic [23:0] ld,
                       input logic [1:0] f, input logic b);
        @(negedge clk_1hz);
        btn_set = s;
        btn_inc = i;
        btn_dec = d;
        @(posedge clk_1hz);
        exp_q.push_back({m, ld, f, b});
        name_q.push_back(nm);
    endtask

    initial begin
        rst      = 1'b1;
        btn_set  = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        time_cur = 24'h123456;
        #1 check("reset_values", observed(), '0);
        @(negedge clk_1hz);
        rst = 1'b0;
        cyc("post_reset_0", 0, 0, 0, 2'b00, 24'h000000, 2'b00, 1'b0);
        cyc("post_reset_1", 0, 0, 0, 2'b00, 24'h000000, 2'b00, 1'b0);

        // capture, hour wrap up and back down, then idle out
        time_cur = 24'h235958;
        cyc("set_enter_h",  1, 0, 0, 2'b10, 24'h235958, 2'b01, 1'b1);
        cyc("h_release",    0, 0, 0, 2'b10, 24'h235958, 2'b01, 1'b0);
        cyc("inc_h23_00",   0, 1, 0, 2'b10, 24'h005958, 2'b01, 1'b1);
        cyc("h_release2",   0, 0, 0, 2'b10, 24'h005958, 2'b01, 1'b0);
        cyc("dec_h00_23",   0, 0, 1, 2'b10, 24'h235958, 2'b01, 1'b1);
        cyc("h_idle1",      0, 0, 0, 2'b10, 24'h235958, 2'b01, 1'b0);
        cyc("h_idle2",      0, 0, 0, 2'b10, 24'h235958, 2'b01, 1'b1);
        cyc("h_idle3",      0, 0, 0, 2'b10, 24'h235958, 2'b01, 1'b0);
        cyc("h_timeout",    0, 0, 0, 2'b00, 24'h235958, 2'b00, 1'b0);

        // full edit ending in a one-cycle load of 10:59:00
        time_cur = 24'h090059;
        cyc("fe_set",       1, 0, 0, 2'b10, 24'h090059, 2'b01, 1'b1);
        cyc("fe_rel1",      0, 0, 0, 2'b10, 24'h090059, 2'b01, 1'b0);
        cyc("fe_inc_h0910", 0, 1, 0, 2'b10, 24'h100059, 2'b01, 1'b1);
        cyc("fe_rel2",      0, 0, 0, 2'b10, 24'h100059, 2'b01, 1'b0);
        cyc("fe_set_m",     1, 0, 0, 2'b10, 24'h100059, 2'b10, 1'b1);
        cyc("fe_rel3",      0, 0, 0, 2'b10, 24'h100059, 2'b10, 1'b0);
        cyc("fe_dec_m0059", 0, 0, 1, 2'b10, 24'h105959, 2'b10, 1'b1);
        cyc("fe_rel4",      0, 0, 0, 2'b10, 24'h105959, 2'b10, 1'b0);
        cyc("fe_set_s",     1, 0, 0, 2'b10, 24'h105959, 2'b11, 1'b1);
        cyc("fe_rel5",      0, 0, 0, 2'b10, 24'h105959, 2'b11, 1'b0);
        cyc("fe_inc_s5900", 0, 1, 0, 2'b10, 24'h105900, 2'b11, 1'b1);
        cyc("fe_rel6",      0, 0, 0, 2'b10, 24'h105900, 2'b11, 1'b0);
        cyc("fe_commit",    1, 0, 0, 2'b01, 24'h105900, 2'b00, 1'b0);
        cyc("fe_run",       0, 0, 0, 2'b00, 24'h105900, 2'b00, 1'b0);
        cyc("fe_run2",      0, 0, 0, 2'b00, 24'h105900, 2'b00, 1'b0);

        // untouched edit times out after 4 hold cycles, never loading
        time_cur = 24'h010203;
        cyc("to_set",       1, 0, 0, 2'b10, 24'h010203, 2'b01, 1'b1);
        cyc("to_idle1",     0, 0, 0, 2'b10, 24'h010203, 2'b01, 1'b0);
        cyc("to_idle2",     0, 0, 0, 2'b10, 24'h010203, 2'b01, 1'b1);
        cyc("to_idle3",     0, 0, 0, 2'b10, 24'h010203, 2'b01, 1'b0);
        cyc("to_run",       0, 0, 0, 2'b00, 24'h010203, 2'b00, 1'b0);
        cyc("to_run2",      0, 0, 0, 2'b00, 24'h010203, 2'b00, 1'b0);

        // set+inc in EDIT_M, inc+dec in EDIT_S (clears idle count)
        time_cur = 24'h123456;
        cyc("sim_set",      1, 0, 0, 2'b10, 24'h123456, 2'b01, 1'b1);
        cyc("sim_rel1",     0, 0, 0, 2'b10, 24'h123456, 2'b01, 1'b0);
        cyc("sim_set_m",    1, 0, 0, 2'b10, 24'h123456, 2'b10, 1'b1);
        cyc("sim_rel2",     0, 0, 0, 2'b10, 24'h123456, 2'b10, 1'b0);
        cyc("sim_set_inc",  1, 1, 0, 2'b10, 24'h123456, 2'b11, 1'b1);
        cyc("sim_rel3",     0, 0, 0, 2'b10, 24'h123456, 2'b11, 1'b0);
        cyc("sim_inc_dec",  0, 1, 1, 2'b10, 24'h123456, 2'b11, 1'b1);
        cyc("sim_idle1",    0, 0, 0, 2'b10, 24'h123456, 2'b11, 1'b0);
        cyc("sim_idle2",    0, 0, 0, 2'b10, 24'h123456, 2'b11, 1'b1);
        cyc("sim_idle3",    0, 0, 0, 2'b10, 24'h123456, 2'b11, 1'b0);

        // asynchronous reset while in EDIT_S
        @(negedge clk_1hz);
        #1 rst = 1'b1;
        #1 check("rst_mid_edit", observed(), '0);
        cyc("rst_hold",     0, 0, 0, 2'b00, 24'h000000, 2'b00, 1'b0);
        @(negedge clk_1hz);
        rst = 1'b0;
        cyc("rst_after0",   0, 0, 0, 2'b00, 24'h000000, 2'b00, 1'b0);
        cyc("rst_after1",   0, 0, 0, 2'b00, 24'h000000, 2'b00, 1'b0);
        cyc("rst_after2",   0, 0, 0, 2'b00, 24'h000000, 2'b00, 1'b0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(negedge clk_1hz);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
